// File: rtl/axis_spi_pkg.sv
// Shared types and helpers for the AXI-Stream SPI arbiter.
package axis_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_DRAIN,
        ST_DROP
    } arb_state_e;

    // Field width for n choices; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_spi_arbiter_rr.sv
// Combinational round-robin selector: first requester after i_last wins.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin : p_sel
        int w_pos;
        o_grant = '0;
        o_idx   = '0;
        w_pos   = 0;
        // Walk from lowest to highest priority so the nearest request wins.
        for (int k = N; k >= 1; k--) begin
            w_pos = (int'(i_last) + k) % N;
            if (i_req[IDX_W'(w_pos)]) begin
                o_grant                 = '0;
                o_grant[IDX_W'(w_pos)]  = 1'b1;
                o_idx                   = IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/axis_spi_arbiter.sv
// Shares one AXI-Stream SPI master between REQ_NUM requesters,
// holding chip select for a whole transaction.
module axis_spi_arbiter
    import axis_spi_pkg::*;
#(
    parameter int   REQ_NUM    = 2,
    parameter int   DATA_WIDTH = 8,
    parameter int   SLAVE_NUM  = 2,
    localparam int  ADDR_W     = clog2_min1(SLAVE_NUM),
    localparam int  IDX_W      = clog2_min1(REQ_NUM)
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] req_tdata_i,
    input  logic [REQ_NUM-1:0]            req_tvalid_i,
    input  logic [REQ_NUM-1:0]            req_tlast_i,
    input  logic [REQ_NUM*ADDR_W-1:0]     req_addr_i,
    output logic [REQ_NUM-1:0]            req_tready_o,
    output logic [DATA_WIDTH-1:0]         rsp_tdata_o,
    output logic [REQ_NUM-1:0]            rsp_tvalid_o,
    output logic                          rsp_tlast_o,
    input  logic [REQ_NUM-1:0]            rsp_tready_i,
    output logic [DATA_WIDTH-1:0]         spi_tdata_o,
    output logic                          spi_tvalid_o,
    output logic                          spi_tlast_o,
    input  logic                          spi_tready_i,
    input  logic [DATA_WIDTH-1:0]         spi_tdata_i,
    input  logic                          spi_tvalid_i,
    input  logic                          spi_tlast_i,
    output logic                          spi_tready_o,
    output logic [ADDR_W-1:0]             spi_addr_o,
    output logic [REQ_NUM-1:0]            grant_o,
    output logic                          err_o
);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [REQ_NUM-1:0]    r_grant;
    logic [IDX_W-1:0]      r_last;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_err;

    logic [REQ_NUM-1:0]    w_rr_grant;
    logic [IDX_W-1:0]      w_rr_idx;
    logic [DATA_WIDTH-1:0] w_tdata [REQ_NUM];
    logic [ADDR_W-1:0]     w_addr  [REQ_NUM];
    logic                  w_any;
    logic                  w_bad;
    logic                  w_gvalid;
    logic                  w_glast;
    logic                  w_grdy;

    for (genvar i = 0; i < REQ_NUM; i++) begin : g_unpack
        assign w_tdata[i] = req_tdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_addr[i]  = req_addr_i[i*ADDR_W +: ADDR_W];
    end

    rr_arbiter #(
        .N     (REQ_NUM),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req   (req_tvalid_i),
        .i_last  (r_last),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx)
    );

    // r_last doubles as the index of the active grant.
    assign w_any    = |req_tvalid_i;
    assign w_bad    = 32'(w_addr[w_rr_idx]) >= SLAVE_NUM;
    assign w_gvalid = req_tvalid_i[r_last];
    assign w_glast  = req_tlast_i[r_last];
    assign w_grdy   = rsp_tready_i[r_last];

    assign rsp_tdata_o = spi_tdata_i;
    assign rsp_tlast_o = spi_tlast_i;
    assign spi_addr_o  = r_addr;
    assign grant_o     = r_grant;
    assign err_o       = r_err;

    always_comb begin
        w_state_nxt  = r_state;
        req_tready_o = '0;
        spi_tdata_o  = '0;
        spi_tvalid_o = 1'b0;
        spi_tlast_o  = 1'b0;
        rsp_tvalid_o = '0;
        spi_tready_o = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = w_bad ? ST_DROP : ST_FWD;
                end
            end
            ST_FWD: begin
                spi_tdata_o  = w_tdata[r_last];
                spi_tvalid_o = w_gvalid;
                spi_tlast_o  = w_glast;
                req_tready_o = r_grant & {REQ_NUM{spi_tready_i}};
                rsp_tvalid_o = r_grant & {REQ_NUM{spi_tvalid_i}};
                spi_tready_o = w_grdy;
                if (w_gvalid && w_glast && spi_tready_i) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                rsp_tvalid_o = r_grant & {REQ_NUM{spi_tvalid_i}};
                spi_tready_o = w_grdy;
                if (spi_tvalid_i && w_grdy && spi_tlast_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                req_tready_o = r_grant;
                if (w_gvalid && w_glast) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_grant <= '0;
            r_last  <= IDX_W'(REQ_NUM - 1);
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= (r_state == ST_DROP) && w_gvalid && w_glast;
            if (r_state == ST_IDLE && w_any) begin
                r_grant <= w_rr_grant;
                r_last  <= w_rr_idx;
                r_addr  <= w_addr[w_rr_idx];
            end else if (w_state_nxt == ST_IDLE) begin
                r_grant <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axis_spi_arbiter.sv
// Directed self-checking bench for axis_spi_arbiter.
// Three slaves give a 2-bit address field, so address 3 is out of range.
module tb_axis_spi_arbiter;

    logic        clk = 1'b0;
    logic        arstn_i;
    logic [15:0] req_tdata_i;
    logic [1:0]  req_tvalid_i;
    logic [1:0]  req_tlast_i;
    logic [3:0]  req_addr_i;
    logic [1:0]  req_tready_o;
    logic [7:0]  rsp_tdata_o;
    logic [1:0]  rsp_tvalid_o;
    logic        rsp_tlast_o;
    logic [1:0]  rsp_tready_i;
    logic [7:0]  spi_tdata_o;
    logic        spi_tvalid_o;
    logic        spi_tlast_o;
    logic        spi_tready_i;
    logic [7:0]  spi_tdata_i;
    logic        spi_tvalid_i;
    logic        spi_tlast_i;
    logic        spi_tready_o;
    logic [1:0]  spi_addr_o;
    logic [1:0]  grant_o;
    logic        err_o;

    int n_chk  = 0;
    int n_fail = 0;

    int         src_rem [2];
    int         src_len [2];
    int         src_cnt [2];
    logic [7:0] src_base[2];
    logic [1:0] src_addr[2];
    bit         src_hs  [2];
    bit         rsp_hs;
    logic [8:0] spi_q[$];

    always #5 clk = ~clk;

    axis_spi_arbiter #(
        .REQ_NUM    (2),
        .DATA_WIDTH (8),
        .SLAVE_NUM  (3)
    ) dut (
        .clk_i        (clk),
        .arstn_i      (arstn_i),
        .req_tdata_i  (req_tdata_i),
        .req_tvalid_i (req_tvalid_i),
        .req_tlast_i  (req_tlast_i),
        .req_addr_i   (req_addr_i),
        .req_tready_o (req_tready_o),
        .rsp_tdata_o  (rsp_tdata_o),
        .rsp_tvalid_o (rsp_tvalid_o),
        .rsp_tlast_o  (rsp_tlast_o),
        .rsp_tready_i (rsp_tready_i),
        .spi_tdata_o  (spi_tdata_o),
        .spi_tvalid_o (spi_tvalid_o),
        .spi_tlast_o  (spi_tlast_o),
        .spi_tready_i (spi_tready_i),
        .spi_tdata_i  (spi_tdata_i),
        .spi_tvalid_i (spi_tvalid_i),
        .spi_tlast_i  (spi_tlast_i),
        .spi_tready_o (spi_tready_o),
        .spi_addr_o   (spi_addr_o),
        .grant_o      (grant_o),
        .err_o        (err_o)
    );

    // Requester sources: byte k of a stream is base+k, tlast every len beats.
    always_comb begin
        req_tdata_i  = '0;
        req_tvalid_i = '0;
        req_tlast_i  = '0;
        req_addr_i   = '0;
        for (int i = 0; i < 2; i++) begin
            req_tvalid_i[i]       = src_rem[i] > 0;
            req_tlast_i[i]        = (src_cnt[i] % src_len[i]) == src_len[i] - 1;
            req_tdata_i[i*8 +: 8] = src_base[i] + 8'(src_cnt[i]);
            req_addr_i[i*2 +: 2]  = src_addr[i];
        end
    end

    // SPI master stand-in: every accepted byte echoes back inverted, same tlast.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            src_hs[i] = req_tvalid_i[i] && req_tready_o[i];
        end
        rsp_hs = spi_tvalid_i && spi_tready_o;
        if (spi_tvalid_o && spi_tready_i) begin
            spi_q.push_back({spi_tlast_o, ~spi_tdata_o});
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (src_hs[i]) begin
                src_cnt[i] = src_cnt[i] + 1;
                if (src_rem[i] > 0) src_rem[i] = src_rem[i] - 1;
                src_hs[i] = 1'b0;
            end
        end
        if (rsp_hs) begin
            if (spi_q.size() > 0) void'(spi_q.pop_front());
            rsp_hs = 1'b0;
        end
        spi_tvalid_i = spi_q.size() != 0;
        if (spi_q.size() != 0) {spi_tlast_i, spi_tdata_i} = spi_q[0];
    end

    task automatic clear_env();
        for (int i = 0; i < 2; i++) begin
            src_rem[i]  = 0;
            src_len[i]  = 1;
            src_cnt[i]  = 0;
            src_base[i] = 8'h00;
            src_addr[i] = 2'd0;
            src_hs[i]   = 1'b0;
        end
        rsp_hs = 1'b0;
        spi_q.delete();
        spi_tvalid_i = 1'b0;
        spi_tdata_i  = 8'h00;
        spi_tlast_i  = 1'b0;
        spi_tready_i = 1'b1;
        rsp_tready_i = 2'b11;
    endtask

    task automatic do_reset();
        arstn_i = 1'b0;
        clear_env();
        repeat (2) @(negedge clk);
        #1 arstn_i = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        arstn_i = 1'b0;
        clear_env();
        @(negedge clk);
        #1;
        n_chk++;
        if (grant_o !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_grant: got %b want 00", grant_o);
        end
        n_chk++;
        if ({spi_addr_o, err_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_addr_err: got %b want 000", {spi_addr_o, err_o});
        end
        n_chk++;
        if ({req_tready_o, rsp_tvalid_o, spi_tvalid_o, spi_tready_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_handshakes: got %b want 000000",
                     {req_tready_o, rsp_tvalid_o, spi_tvalid_o, spi_tready_o});
        end
        #1 arstn_i = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic test_single();
        do_reset();
        src_addr[0] = 2'd1;
        src_base[0] = 8'hA5;
        src_len[0]  = 1;
        src_rem[0]  = 1;
        #1;
        n_chk++;
        if ({req_tready_o, spi_tvalid_o, grant_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL single_idle: got %b want 00000",
                     {req_tready_o, spi_tvalid_o, grant_o});
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (grant_o !== 2'b01) begin
            n_fail++;
            $display("FAIL single_grant: got %b want 01", grant_o);
        end
        n_chk++;
        if (spi_addr_o !== 2'd1) begin
            n_fail++;
            $display("FAIL single_addr_fwd: got %0d want 1", spi_addr_o);
        end
        n_chk++;
        if ({spi_tvalid_o, spi_tlast_o, spi_tdata_o, req_tready_o} !== {2'b11, 8'hA5, 2'b01}) begin
            n_fail++;
            $display("FAIL single_fwd: got v%b l%b d%h r%b want v1 l1 da5 r01",
                     spi_tvalid_o, spi_tlast_o, spi_tdata_o, req_tready_o);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if ({rsp_tvalid_o, rsp_tlast_o, rsp_tdata_o, spi_tready_o} !== {2'b01, 1'b1, 8'h5A, 1'b1}) begin
            n_fail++;
            $display("FAIL single_rsp: got v%b l%b d%h r%b want v01 l1 d5a r1",
                     rsp_tvalid_o, rsp_tlast_o, rsp_tdata_o, spi_tready_o);
        end
        n_chk++;
        if ({spi_addr_o, spi_tvalid_o, grant_o} !== {2'd1, 1'b0, 2'b01}) begin
            n_fail++;
            $display("FAIL single_drain: got a%0d v%b g%b want a1 v0 g01",
                     spi_addr_o, spi_tvalid_o, grant_o);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if ({grant_o, rsp_tvalid_o, spi_tready_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL single_release: got g%b v%b r%b want g00 v00 r0",
                     grant_o, rsp_tvalid_o, spi_tready_o);
        end
    endtask

    task automatic test_contention();
        logic [1:0] g_seen[4];
        logic [1:0] a_seen[4];
        int         z_seen[4];
        int         ng;
        int         zrun;
        logic [1:0] prev;
        logic [1:0] exp_g;
        do_reset();
        src_addr[0] = 2'd0; src_base[0] = 8'h40; src_len[0] = 2; src_rem[0] = 100;
        src_addr[1] = 2'd1; src_base[1] = 8'h80; src_len[1] = 2; src_rem[1] = 100;
        ng   = 0;
        zrun = 0;
        prev = 2'b00;
        for (int c = 0; c < 300 && ng < 4; c++) begin
            @(negedge clk);
            #1;
            if (grant_o == 2'b00) begin
                zrun++;
            end else if (prev == 2'b00) begin
                g_seen[ng] = grant_o;
                a_seen[ng] = spi_addr_o;
                z_seen[ng] = zrun;
                ng++;
                zrun = 0;
            end
            prev = grant_o;
        end
        n_chk++;
        if (ng !== 4) begin
            n_fail++;
            $display("FAIL contention_timeout: got %0d grants want 4", ng);
        end
        for (int k = 0; k < ng; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_chk++;
            if ({g_seen[k], a_seen[k]} !== {exp_g, 2'(k % 2)}) begin
                n_fail++;
                $display("FAIL contention_grant%0d: got g%b a%0d want g%b a%0d",
                         k, g_seen[k], a_seen[k], exp_g, k % 2);
            end
            if (k > 0) begin
                n_chk++;
                if (z_seen[k] !== 1) begin
                    n_fail++;
                    $display("FAIL contention_bubble%0d: got %0d want 1", k, z_seen[k]);
                end
            end
        end
    endtask

    task automatic test_bad_addr();
        int  acc;
        int  spi_v;
        int  errs;
        bit  saw_g;
        do_reset();
        src_addr[1] = 2'd3; src_base[1] = 8'h60; src_len[1] = 3; src_rem[1] = 3;
        acc   = 0;
        spi_v = 0;
        errs  = 0;
        saw_g = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_tvalid_i[1] && req_tready_o[1]) acc++;
            if (spi_tvalid_o || rsp_tvalid_o != 2'b00) spi_v++;
            if (err_o) errs++;
            if (grant_o == 2'b10) saw_g = 1'b1;
            @(negedge clk);
        end
        #1;
        n_chk++;
        if (acc !== 3) begin
            n_fail++;
            $display("FAIL bad_addr_beats: got %0d want 3", acc);
        end
        n_chk++;
        if (spi_v !== 0) begin
            n_fail++;
            $display("FAIL bad_addr_spi_valid: got %0d cycles want 0", spi_v);
        end
        n_chk++;
        if (errs !== 1) begin
            n_fail++;
            $display("FAIL bad_addr_err: got %0d pulses want 1", errs);
        end
        n_chk++;
        if ({saw_g, grant_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL bad_addr_grant: got seen%b g%b want seen1 g00", saw_g, grant_o);
        end
    endtask

    task automatic test_backpressure();
        bit found;
        int bad;
        bit bubble;
        bit regrant;
        do_reset();
        rsp_tready_i = 2'b10;
        src_addr[0] = 2'd0; src_base[0] = 8'h11; src_len[0] = 1; src_rem[0] = 1;
        src_addr[1] = 2'd2; src_base[1] = 8'h22; src_len[1] = 1; src_rem[1] = 1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            #1;
            if (grant_o == 2'b01 && spi_tvalid_i && !spi_tvalid_o) found = 1'b1;
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL bp_drain_timeout: got no drain want drain with pending rsp");
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            n_chk++;
            if ({spi_tready_o, grant_o, rsp_tvalid_o} !== 5'b00101) begin
                n_fail++;
                bad++;
                $display("FAIL bp_hold%0d: got r%b g%b v%b want r0 g01 v01",
                         c, spi_tready_o, grant_o, rsp_tvalid_o);
            end
            @(negedge clk);
            #1;
        end
        rsp_tready_i = 2'b11;
        bubble  = 1'b0;
        regrant = 1'b0;
        for (int c = 0; c < 10 && !regrant; c++) begin
            @(negedge clk);
            #1;
            if (grant_o == 2'b00) bubble = 1'b1;
            if (grant_o == 2'b10) regrant = 1'b1;
        end
        n_chk++;
        if ({bubble, regrant} !== 2'b11) begin
            n_fail++;
            $display("FAIL bp_release: got bubble%b grant1%b want 11", bubble, regrant);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        do_reset();
        src_addr[0] = 2'd2; src_base[0] = 8'h30; src_len[0] = 4; src_rem[0] = 4;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            #1;
            if (src_cnt[0] == 1) found = 1'b1;
        end
        n_chk++;
        if ({found, grant_o, spi_addr_o} !== {1'b1, 2'b01, 2'd2}) begin
            n_fail++;
            $display("FAIL rstmid_setup: got f%b g%b a%0d want f1 g01 a2",
                     found, grant_o, spi_addr_o);
        end
        arstn_i = 1'b0;
        #1;
        n_chk++;
        if ({grant_o, spi_addr_o, err_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL rstmid_regs: got g%b a%0d e%b want g00 a0 e0",
                     grant_o, spi_addr_o, err_o);
        end
        n_chk++;
        if ({req_tready_o, spi_tvalid_o, rsp_tvalid_o, spi_tready_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL rstmid_handshakes: got %b want 000000",
                     {req_tready_o, spi_tvalid_o, rsp_tvalid_o, spi_tready_o});
        end
        clear_env();
        @(negedge clk);
        #1 arstn_i = 1'b1;
        src_len[0] = 1; src_rem[0] = 1;
        src_len[1] = 1; src_rem[1] = 1; src_addr[1] = 2'd1;
        @(negedge clk);
        #1;
        n_chk++;
        if (grant_o !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_regrant: got %b want 01", grant_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_bad_addr();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
